// File: rtl/uart_cmd_parser.sv
// Purpose : assembles "<letter>[blanks][hex digits]<CHAR_END>" lines from a UART byte stream into one decoded command.
// Latency : cmd_vld rises 1 cycle after the terminator transfers; err pulses 1 cycle after the offending byte.
// Backpr. : rdy_rx drops while a command waits for cmd_rdy (and, with echo, while an echo byte waits for tx_rdy).
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   d_rx/vld_rx/rdy_rx byte input handshake from the UART receiver
//   cmd/arg/arg_cnt    decoded command letter (uppercase), right-aligned argument, digit count
//   cmd_vld/cmd_rdy    command output handshake
//   err                one-cycle pulse when a line is rejected
//   tx_d/tx_vld/tx_rdy echo of every accepted byte (only when UART_CMD_ECHO_EN is defined)
//
// Build option: define UART_CMD_ECHO_EN to add the echo port and logic.
module uart_cmd_parser #(
    parameter int         ARG_DIGITS = 8,
    parameter int         ARG_W      = 4 * ARG_DIGITS,
    parameter logic [7:0] CHAR_END   = 8'h0D
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [7:0]       d_rx,
    input  logic             vld_rx,
    output logic             rdy_rx,
    output logic [7:0]       cmd,
    output logic [ARG_W-1:0] arg,
    output logic [3:0]       arg_cnt,
    output logic             cmd_vld,
    input  logic             cmd_rdy,
    output logic             err
`ifdef UART_CMD_ECHO_EN
    ,
    output logic [7:0]       tx_d,
    output logic             tx_vld,
    input  logic             tx_rdy
`endif
);

    typedef enum logic [1:0] {IDLE, ARG, DONE, FLUSH} state_t;

    state_t state;
    state_t state_nxt;

    logic              take;
    logic              is_blank;
    logic              is_end;
    logic              is_upper;
    logic              is_lower;
    logic              is_letter;
    logic              is_dec;
    logic              is_hex_alpha;
    logic              is_hex;
    logic              digit_full;
    logic [3:0]        nibble;
    logic [7:0]        upper;
    logic [ARG_W+3:0]  shifted;
    logic              tx_vld_nxt;

    // Byte classification of the byte currently offered by the receiver.
    always_comb begin
        take         = vld_rx && rdy_rx;
        is_blank     = (d_rx == 8'h20) || (d_rx == 8'h0A);
        is_end       = (d_rx == CHAR_END);
        is_upper     = (d_rx >= 8'h41) && (d_rx <= 8'h5A);
        is_lower     = (d_rx >= 8'h61) && (d_rx <= 8'h7A);
        is_letter    = is_upper || is_lower;
        is_dec       = (d_rx >= 8'h30) && (d_rx <= 8'h39);
        is_hex_alpha = ((d_rx >= 8'h41) && (d_rx <= 8'h46)) ||
                       ((d_rx >= 8'h61) && (d_rx <= 8'h66));
        is_hex       = is_dec || is_hex_alpha;
        // 'A'/'a' have low nibble 1, so +9 maps A..F onto 10..15.
        nibble       = 4'h0;
        if (is_dec)
            nibble = d_rx[3:0];
        else if (is_hex_alpha)
            nibble = d_rx[3:0] + 4'd9;
        upper        = is_lower ? (d_rx & 8'hDF) : d_rx;
        // Concatenate then truncate so ARG_DIGITS=1 needs no special slice.
        shifted      = {arg, nibble};
        digit_full   = (arg_cnt == 4'(ARG_DIGITS));
    end

    // Next-state decode; shared by the state register, err and the registered rdy_rx.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take && !is_end && !is_blank)
                    state_nxt = is_letter ? ARG : FLUSH;
            end
            ARG: begin
                if (take) begin
                    if (is_end)
                        state_nxt = DONE;
                    else if (is_blank || (is_hex && !digit_full))
                        state_nxt = ARG;
                    else
                        state_nxt = FLUSH;
                end
            end
            DONE: begin
                if (cmd_vld && cmd_rdy)
                    state_nxt = IDLE;
            end
            FLUSH: begin
                if (take && is_end)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef UART_CMD_ECHO_EN
    // rdy_rx is held low while an echo is pending, so a new byte can only
    // be taken when the echo slot is (or is about to be) empty.
    always_comb begin
        tx_vld_nxt = tx_vld;
        if (take)
            tx_vld_nxt = 1'b1;
        else if (tx_vld && tx_rdy)
            tx_vld_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_vld <= 1'b0;
            tx_d   <= 8'h00;
        end else begin
            tx_vld <= tx_vld_nxt;
            if (take)
                tx_d <= d_rx;
        end
    end
`else
    always_comb tx_vld_nxt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            rdy_rx  <= 1'b0;
            cmd     <= 8'h00;
            arg     <= '0;
            arg_cnt <= 4'h0;
            cmd_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_rx <= (state_nxt != DONE) && !tx_vld_nxt;
            // Only entering FLUSH from a parsing state is an error; staying in FLUSH is silent.
            err    <= ((state == IDLE) || (state == ARG)) && (state_nxt == FLUSH);
            case (state)
                IDLE: begin
                    if (state_nxt == ARG) begin
                        cmd     <= upper;
                        arg     <= '0;
                        arg_cnt <= 4'h0;
                    end
                end
                ARG: begin
                    if (state_nxt == DONE) begin
                        cmd_vld <= 1'b1;
                    end else if (take && is_hex && (state_nxt == ARG)) begin
                        arg     <= shifted[ARG_W-1:0];
                        arg_cnt <= arg_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (cmd_vld && cmd_rdy)
                        cmd_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
